// File: rtl/n_sort_pipe.sv
// Pipelined odd-even transposition sorter with a valid/ready handshake and per-vector asc/desc mode.
// Optional macro SORT_TAG_EN adds index tags that travel with each element (idx_out port).
module n_sort_pipe #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int IDXW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] data_in,
    input  logic               desc_in,
    input  logic               valid_in,
    output logic               ready_in,
    output logic [N*WIDTH-1:0] data_out,
    output logic               desc_out,
    output logic               valid_out,
    input  logic               ready_out
`ifdef SORT_TAG_EN
    ,
    output logic [N*IDXW-1:0]  idx_out
`endif
);

    localparam int LAST = N - 1;

    if (N < 2 || N > 16 || IDXW < $clog2(N)) begin : g_bad_param
        $error("n_sort_pipe: N must be 2..16 and IDXW at least clog2(N)");
    end

    logic [WIDTH-1:0] data_q   [N][N];
    logic [WIDTH-1:0] data_d   [N][N];
    logic [WIDTH-1:0] src_data [N][N];
    logic [WIDTH-1:0] lay_data [N][N];
    logic             desc_q   [N];
    logic             desc_d   [N];
    logic             src_desc [N];
    logic             valid_q  [N];
    logic             valid_d  [N];
    logic             src_valid[N];
    logic             advance;
`ifdef SORT_TAG_EN
    logic [IDXW-1:0]  idx_q    [N][N];
    logic [IDXW-1:0]  idx_d    [N][N];
    logic [IDXW-1:0]  src_idx  [N][N];
    logic [IDXW-1:0]  lay_idx  [N][N];
`endif

    // Stage s works on what stage s-1 holds; stage 0 works on the incoming vector.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            src_data[0][k] = data_in[k*WIDTH +: WIDTH];
`ifdef SORT_TAG_EN
            src_idx[0][k] = IDXW'(k);
`endif
        end
        src_desc[0]  = desc_in;
        src_valid[0] = valid_in;
        for (int s = 1; s < N; s++) begin
            src_data[s]  = data_q[s-1];
            src_desc[s]  = desc_q[s-1];
            src_valid[s] = valid_q[s-1];
`ifdef SORT_TAG_EN
            src_idx[s] = idx_q[s-1];
`endif
        end
    end

    // Strict compare-exchange keeps equal values in their original order.
    always_comb begin
        lay_data = src_data;
`ifdef SORT_TAG_EN
        lay_idx = src_idx;
`endif
        for (int s = 0; s < N; s++) begin
            for (int i = 0; i < N - 1; i++) begin
                if ((i % 2) == (s % 2)) begin
                    if (src_desc[s] ? (src_data[s][i] < src_data[s][i+1])
                                    : (src_data[s][i] > src_data[s][i+1])) begin
                        lay_data[s][i]   = src_data[s][i+1];
                        lay_data[s][i+1] = src_data[s][i];
`ifdef SORT_TAG_EN
                        lay_idx[s][i]    = src_idx[s][i+1];
                        lay_idx[s][i+1]  = src_idx[s][i];
`endif
                    end
                end
            end
        end
    end

    always_comb begin
        advance = ~valid_q[LAST] | ready_out;
        for (int s = 0; s < N; s++) begin
            valid_d[s] = advance ? src_valid[s] : valid_q[s];
            desc_d[s]  = advance ? src_desc[s]  : desc_q[s];
            data_d[s]  = advance ? lay_data[s]  : data_q[s];
`ifdef SORT_TAG_EN
            idx_d[s]   = advance ? lay_idx[s]   : idx_q[s];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < N; s++) begin
                valid_q[s] <= 1'b0;
                desc_q[s]  <= 1'b0;
                for (int k = 0; k < N; k++) begin
                    data_q[s][k] <= '0;
`ifdef SORT_TAG_EN
                    idx_q[s][k]  <= '0;
`endif
                end
            end
        end else begin
            valid_q <= valid_d;
            desc_q  <= desc_d;
            data_q  <= data_d;
`ifdef SORT_TAG_EN
            idx_q   <= idx_d;
`endif
        end
    end

    always_comb begin
        ready_in  = advance;
        valid_out = valid_q[LAST];
        desc_out  = desc_q[LAST];
        data_out  = '0;
`ifdef SORT_TAG_EN
        idx_out   = '0;
`endif
        for (int k = 0; k < N; k++) begin
            data_out[k*WIDTH +: WIDTH] = data_q[LAST][k];
`ifdef SORT_TAG_EN
            idx_out[k*IDXW +: IDXW] = idx_q[LAST][k];
`endif
        end
    end

endmodule
